dec_engine_scheduler: RTL and testbench
=======================================

Name: dec_engine_scheduler

Overview:
- Shares one pipelined fp32 8-tap decomposition engine (multiplier bank plus 3-level adder tree, in-order, one job per cycle) between up to 4 decomposition-level requesters.
- Grants round-robin, bounds outstanding jobs per requester with credits, and tags each issued job so the engine's result strobe routes back to its owner.
- Sits in the clk_312_5 domain between the level front-ends and the shared engine; the operand mux and result fan-out are external and driven by eng_sel / rsp_valid.

Parameters:
- NUM_REQ, 3, number of requesters (legal 2..4).
- MAX_OUT, 4, max outstanding jobs per requester (1..15).
- FIFO_DEPTH, 32, tag FIFO depth, power of 2; total outstanding jobs limit.

Ports:
- clk_312_5  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight jobs drain.
- req  in  NUM_REQ  per-requester job request, level; held until granted.
- gnt  out  NUM_REQ  one-hot grant, combinational from req and registered state.
- eng_issue  out  1  engine job-valid, equals |gnt.
- eng_sel  out  2  index of granted requester (operand mux select); 0 when no grant.
- eng_done  in  1  engine result-valid strobe, one per issued job, in issue order.
- rsp_valid  out  NUM_REQ  registered one-hot result-owner strobe.
- busy  out  1  registered; 1 while any job is outstanding.
- err_underflow  out  1  sticky: eng_done seen with no outstanding job.

Behaviour:
- Reset (async, rstn=0): gnt=0, eng_issue=0, eng_sel=0, rsp_valid=0, busy=0, err_underflow=0. RR pointer = NUM_REQ-1, so requester 0 has first priority. Credits=0, FIFO empty.
- Eligibility of requester i in cycle t: req[i]=1, credit[i]<MAX_OUT, FIFO count<FIFO_DEPTH, enable=1.
- FIFO-full check ignores a same-cycle pop.
- Arbitration: search eligible requesters starting at ptr+1 mod NUM_REQ. The first hit gets gnt[i]=1 in the same cycle, with eng_issue=1 and eng_sel=i. At most one grant per cycle.
- On a grant, the clock edge sets ptr<=i, credit[i]++, and pushes i into the tag FIFO.
- Requester holding req after a grant is re-eligible the next cycle. RR order still applies, so with all requesting, grants rotate 0,1,2,0,...
- Completion: on eng_done with FIFO non-empty, pop tag k, credit[k]--. Next cycle rsp_valid[k]=1 for exactly one cycle; rsp_valid latency is 1 cycle after eng_done.
- Same-cycle grant and done: push and pop both occur. If both are the same requester, its credit is unchanged.
- Underflow: eng_done with FIFO empty sets err_underflow=1 (held until reset). No rsp_valid pulse; counters unchanged.
- busy = registered (FIFO count != 0), reflecting the state after each edge.
- enable 1->0 takes effect the same cycle: no grant. Outstanding results still route. Re-enable resumes from the stored ptr.
- Credit and count widths must not wrap: credit saturates logically via eligibility. Count range is 0..FIFO_DEPTH.
- Reset mid-operation clears all state. The engine must be reset together with this block; any result arriving afterwards sets err_underflow by design.
- Requesters with index >= NUM_REQ do not exist; eng_sel is 2 bits regardless.

Test Plan:
- Reset, then req=3'b111 held, enable=1, eng_done=0 -> gnt sequence 001,010,100,001,...; after 12 grants each credit=4 and gnt stays 0; busy=1.
- Same as above, then a single eng_done pulse -> next cycle rsp_valid=001; cycle after the done, requester 0 is eligible again and is granted next, because it is the only eligible requester.
- Fixed engine model with latency 19, req=3'b010 only, MAX_OUT=4 -> grants in cycles 0-3, stall until first done; rsp_valid=010 in cycles 20-23; steady state 4 jobs per 20 cycles.
- FIFO_DEPTH=4, NUM_REQ=3, MAX_OUT=4, all requesting, no done -> exactly 4 grants (0,1,2,0), then none. A done that is simultaneous with a blocked grant attempt does not produce a grant that cycle.
- enable=0 with 3 jobs in flight -> no gnt; three eng_done pulses give three rsp_valid pulses in issue order; busy falls to 0 the cycle after the last done.
- eng_done pulse after reset with nothing issued -> err_underflow=1 and stays 1 through further traffic; rsp_valid stays 0. Asserting rstn=0 mid-burst clears all outputs asynchronously.

Source files
------------

// File: rtl/dec_engine_scheduler.sv
// Round-robin, credit-bounded scheduler sharing one pipelined decomposition
// engine among NUM_REQ level requesters; a tag FIFO routes in-order results back.
module dec_engine_scheduler #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic               clk_312_5,
  input  logic               rstn,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               eng_issue,
  output logic [1:0]         eng_sel,
  input  logic               eng_done,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               busy,
  output logic               err_underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [1:0]    ptr;
  logic [CW-1:0] credit [NUM_REQ];
  logic [1:0]    tag_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [3:0]    elig;
  logic [3:0]    gnt4;
  logic [1:0]    idx;
  logic          found;
  logic          push;
  logic          pop;
  logic [1:0]    pop_tag;

  // FIFO-full test uses the pre-pop count, so a same-cycle done never frees a slot.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = rstn && enable && req[i] &&
                (credit[i] < CW'(MAX_OUT)) &&
                (count < (AW+1)'(FIFO_DEPTH));
    end
  end

  always_comb begin
    gnt4    = '0;
    eng_sel = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = 2'((32'(ptr) + off) % NUM_REQ);
      if (!found && elig[idx]) begin
        found     = 1'b1;
        gnt4[idx] = 1'b1;
        eng_sel   = idx;
      end
    end
  end

  assign gnt       = gnt4[NUM_REQ-1:0];
  assign eng_issue = found;
  assign push      = found;
  assign pop       = eng_done && (count != '0);
  assign pop_tag   = tag_mem[rd_ptr];
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk_312_5) begin
    if (push) tag_mem[wr_ptr] <= eng_sel;
  end

  always_ff @(posedge clk_312_5 or negedge rstn) begin
    if (!rstn) begin
      ptr           <= 2'(NUM_REQ - 1);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rsp_valid     <= '0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit[i] <= '0;
    end else begin
      if (push) begin
        ptr    <= eng_sel;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      busy      <= (count_nxt != '0);
      rsp_valid <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
      if (eng_done && (count == '0)) err_underflow <= 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        credit[i] <= credit[i]
                     + CW'(push && (eng_sel == 2'(i)))
                     - CW'(pop && (pop_tag == 2'(i)));
      end
    end
  end

endmodule

// File: tb/tb_dec_engine_scheduler.sv
// Directed bench for dec_engine_scheduler: default instance plus a 4-deep FIFO instance.
module tb_dec_engine_scheduler;

  logic       clk_312_5 = 1'b0;
  logic       rstn      = 1'b0;
  logic       enable    = 1'b0;
  logic [2:0] req       = '0;
  logic       eng_done  = 1'b0;
  logic [2:0] gnt;
  logic       eng_issue;
  logic [1:0] eng_sel;
  logic [2:0] rsp_valid;
  logic       busy;
  logic       err_underflow;

  logic       s_enable   = 1'b0;
  logic [2:0] s_req      = '0;
  logic       s_done     = 1'b0;
  logic [2:0] s_gnt;
  logic       s_issue;
  logic [1:0] s_sel;
  logic [2:0] s_rsp;
  logic       s_busy;
  logic       s_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_312_5 = ~clk_312_5;

  dec_engine_scheduler #(.NUM_REQ(3), .MAX_OUT(4), .FIFO_DEPTH(32)) u_dut (
    .clk_312_5(clk_312_5), .rstn(rstn), .enable(enable), .req(req),
    .gnt(gnt), .eng_issue(eng_issue), .eng_sel(eng_sel), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .busy(busy), .err_underflow(err_underflow)
  );

  dec_engine_scheduler #(.NUM_REQ(3), .MAX_OUT(4), .FIFO_DEPTH(4)) u_small (
    .clk_312_5(clk_312_5), .rstn(rstn), .enable(s_enable), .req(s_req),
    .gnt(s_gnt), .eng_issue(s_issue), .eng_sel(s_sel), .eng_done(s_done),
    .rsp_valid(s_rsp), .busy(s_busy), .err_underflow(s_err)
  );

  typedef struct {
    logic [2:0] req;
    logic       en;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [2:0] rsp;
    logic       busy;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req      = '0;
    enable   = 1'b0;
    eng_done = 1'b0;
    s_req    = '0;
    s_enable = 1'b0;
    s_done   = 1'b0;
    repeat (2) @(negedge clk_312_5);
    rstn = 1'b1;
  endtask

  // Advance to the next falling edge, apply inputs, settle before checking.
  task automatic step(input logic [2:0] r, input logic en, input logic d);
    @(negedge clk_312_5);
    req      = r;
    enable   = en;
    eng_done = d;
    #1;
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic vec_t mk(input logic [2:0] r, input logic e, input logic d,
                              input logic [2:0] g, input logic [2:0] rs, input logic b);
    vec_t v;
    v.req = r; v.en = e; v.done = d; v.gnt = g; v.sel = sel_of(g); v.rsp = rs; v.busy = b;
    return v;
  endfunction

  initial begin
    logic [2:0] rot [3];
    int         hist [64];
    logic [2:0] exp_g;
    logic [2:0] exp_r;
    logic       d;

    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;
    for (int i = 0; i < 12; i++) tv[i] = mk(3'b111, 1'b1, 1'b0, rot[i % 3], 3'b000, (i != 0));
    tv[12] = mk(3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1);
    tv[13] = mk(3'b111, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
    tv[14] = mk(3'b111, 1'b1, 1'b0, 3'b001, 3'b001, 1'b1);
    tv[15] = mk(3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1);
    tv[16] = mk(3'b111, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
    tv[17] = mk(3'b111, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1);

    // Reset state, with requests asserted to show grants are held off.
    rstn = 1'b0; req = 3'b111; enable = 1'b1;
    #12;
    chk("rst gnt", int'(gnt), 0);
    chk("rst issue", int'(eng_issue), 0);
    chk("rst sel", int'(eng_sel), 0);
    chk("rst rsp", int'(rsp_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst err", int'(err_underflow), 0);

    // Rotation to credit exhaustion, then completion re-enables requesters.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tv[i].req, tv[i].en, tv[i].done);
      chk($sformatf("row%0d gnt", i), int'(gnt), int'(tv[i].gnt));
      chk($sformatf("row%0d sel", i), int'(eng_sel), int'(tv[i].sel));
      chk($sformatf("row%0d issue", i), int'(eng_issue), int'(tv[i].gnt != 0));
      chk($sformatf("row%0d rsp", i), int'(rsp_valid), int'(tv[i].rsp));
      chk($sformatf("row%0d busy", i), int'(busy), int'(tv[i].busy));
    end
    chk("rot err", int'(err_underflow), 0);

    // Engine with 19-cycle latency serving requester 1 only.
    do_reset();
    for (int c = 0; c < 64; c++) hist[c] = 0;
    for (int c = 0; c < 60; c++) begin
      d = (c >= 19) ? hist[c-19][0] : 1'b0;
      step(3'b010, 1'b1, d);
      hist[c] = int'(eng_issue);
      exp_g = ((c % 20) < 4) ? 3'b010 : 3'b000;
      exp_r = ((c >= 20) && ((c % 20) < 4)) ? 3'b010 : 3'b000;
      chk($sformatf("lat c%0d gnt", c), int'(gnt), int'(exp_g));
      chk($sformatf("lat c%0d rsp", c), int'(rsp_valid), int'(exp_r));
    end

    // 4-deep FIFO: four grants then full; a done while full does not unblock that cycle.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_312_5);
      s_req    = 3'b111;
      s_enable = 1'b1;
      s_done   = (c == 6);
      #1;
      exp_g = (c < 4) ? rot[c % 3] : ((c == 7) ? 3'b010 : 3'b000);
      chk($sformatf("fifo c%0d gnt", c), int'(s_gnt), int'(exp_g));
      chk($sformatf("fifo c%0d rsp", c), int'(s_rsp), (c == 7) ? 1 : 0);
    end
    chk("fifo busy", int'(s_busy), 1);

    // enable drop with three jobs in flight; results drain in issue order.
    do_reset();
    step(3'b111, 1'b1, 1'b0); chk("en c0 gnt", int'(gnt), 1);
    step(3'b111, 1'b1, 1'b0); chk("en c1 gnt", int'(gnt), 2);
    step(3'b111, 1'b1, 1'b0); chk("en c2 gnt", int'(gnt), 4);
    step(3'b111, 1'b0, 1'b1); chk("en c3 gnt", int'(gnt), 0);
    chk("en c3 busy", int'(busy), 1);
    step(3'b111, 1'b0, 1'b1); chk("en c4 gnt", int'(gnt), 0);
    chk("en c4 rsp", int'(rsp_valid), 1);
    step(3'b111, 1'b0, 1'b1); chk("en c5 rsp", int'(rsp_valid), 2);
    chk("en c5 busy", int'(busy), 1);
    step(3'b111, 1'b0, 1'b0); chk("en c6 rsp", int'(rsp_valid), 4);
    chk("en c6 busy", int'(busy), 0);
    chk("en c6 gnt", int'(gnt), 0);
    step(3'b111, 1'b1, 1'b0); chk("en c7 gnt", int'(gnt), 1);
    chk("en c7 rsp", int'(rsp_valid), 0);

    // Underflow is sticky; async reset mid-burst clears everything.
    do_reset();
    step(3'b000, 1'b1, 1'b1); chk("uf c0 err", int'(err_underflow), 0);
    step(3'b000, 1'b1, 1'b0); chk("uf c1 err", int'(err_underflow), 1);
    chk("uf c1 rsp", int'(rsp_valid), 0);
    chk("uf c1 busy", int'(busy), 0);
    step(3'b001, 1'b1, 1'b0); chk("uf c2 gnt", int'(gnt), 1);
    step(3'b000, 1'b1, 1'b1); chk("uf c3 err", int'(err_underflow), 1);
    step(3'b000, 1'b1, 1'b0); chk("uf c4 rsp", int'(rsp_valid), 1);
    chk("uf c4 err", int'(err_underflow), 1);
    step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);
    chk("uf burst busy", int'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst gnt", int'(gnt), 0);
    chk("arst issue", int'(eng_issue), 0);
    chk("arst sel", int'(eng_sel), 0);
    chk("arst rsp", int'(rsp_valid), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst err", int'(err_underflow), 0);
    do_reset();
    step(3'b111, 1'b1, 1'b0); chk("post rst gnt", int'(gnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
